bridge_tx_scheduler: RTL and testbench

Round-robin frame scheduler that shares one TX MAC between two receive-side byte FIFOs (port A and port B of the Ethernet bridge). It waits for a complete frame in either FIFO, pops that frame's length entry, reads exactly that many bytes, and streams them to the MAC as `tx_mac_data`/`tx_mac_valid`. It enforces an inter-frame gap and silently drains out-of-range frames. It sits between the per-port `fifo_buff` instances and `mac_controller`.

---
 rtl/bridge_tx_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_bridge_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_tx_scheduler.sv
// -----------------------------------------------------------------------------
// bridge_tx_scheduler
//
// Round-robin frame scheduler that shares one TX MAC between the port A and
// port B receive FIFOs. It waits until a FIFO holds a complete frame, pops
// that frame's length entry, reads exactly that many bytes and streams them to
// the MAC. After each forwarded frame it holds an inter-frame gap of IFG
// cycles. Frames whose length is 0 or outside [MIN_LEN, MAX_LEN] are read out
// of the FIFO without being forwarded, and they are counted in drop_cnt.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   a_frame_rdy/a_frame_len  FIFO A has a complete frame / its byte count
//   a_len_pop                one-cycle pulse that consumes the FIFO A length
//   a_read / a_data          FIFO A byte read strobe / data (valid next cycle)
//   b_*                      the same set of signals for FIFO B
//   tx_mac_ready             MAC can take a new frame (sampled in IDLE only)
//   tx_mac_data/tx_mac_valid byte stream to the MAC
//   grant                    port being served (0 = A, 1 = B), held when idle
//   busy                     high in every state except IDLE
//   drop_cnt                 dropped-frame count, saturating at 255
//   state_dbg                current FSM state, for debug and checkers
//
// Handshake: a frame is offered while *_frame_rdy is high, and *_frame_len is
// valid with it. It is accepted by the one-cycle *_len_pop pulse, and after
// that the FIFO must supply a byte on the cycle after each *_read. The MAC
// side has no per-byte backpressure. tx_mac_ready only gates the start of a
// frame, and each tx_mac_valid cycle carries one byte that the MAC must take.
// -----------------------------------------------------------------------------
module bridge_tx_scheduler #(
    parameter int LEN_W   = 11,
    parameter int IFG     = 12,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_frame_rdy,
    input  logic [LEN_W-1:0] a_frame_len,
    output logic             a_len_pop,
    output logic             a_read,
    input  logic [7:0]       a_data,
    input  logic             b_frame_rdy,
    input  logic [LEN_W-1:0] b_frame_len,
    output logic             b_len_pop,
    output logic             b_read,
    input  logic [7:0]       b_data,
    input  logic             tx_mac_ready,
    output logic [7:0]       tx_mac_data,
    output logic             tx_mac_valid,
    output logic             grant,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [2:0]       state_dbg
);

    localparam int IFG_W = (IFG < 2) ? 1 : $clog2(IFG + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_SEND  = 3'd2,
        S_DRAIN = 3'd3,
        S_IFG   = 3'd4
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [IFG_W-1:0] ifg_cnt;
    logic             rd_d1;       // a forwarded read happened last cycle
    logic             winner;      // port that wins arbitration in IDLE
    logic             len_bad;     // latched length must be drained

    assign state_dbg = state;

    // When both ports are ready, the port that was not served last time wins.
    always_comb begin
        winner = 1'b0;
        if (a_frame_rdy && b_frame_rdy) begin
            winner = ~last_grant;
        end else begin
            winner = b_frame_rdy;
        end
    end

    assign len_bad = (len_q < LEN_W'(MIN_LEN)) || (len_q > LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            grant        <= 1'b1;
            last_grant   <= 1'b1;
            a_len_pop    <= 1'b0;
            b_len_pop    <= 1'b0;
            a_read       <= 1'b0;
            b_read       <= 1'b0;
            tx_mac_valid <= 1'b0;
            tx_mac_data  <= 8'h00;
            busy         <= 1'b0;
            drop_cnt     <= 8'h00;
            len_q        <= '0;
            byte_cnt     <= '0;
            ifg_cnt      <= '0;
            rd_d1        <= 1'b0;
        end else begin
            a_len_pop <= 1'b0;
            b_len_pop <= 1'b0;

            // The read strobe and the state change on the same edge, so
            // looking at state here tells whether this read is forwarded
            // or drained. FIFO data arrives one cycle after the read, and
            // it is registered one cycle after that.
            rd_d1        <= (a_read || b_read) && (state == S_SEND);
            tx_mac_valid <= rd_d1;
            if (rd_d1) begin
                tx_mac_data <= grant ? b_data : a_data;
            end

            case (state)
                S_IDLE: begin
                    if (tx_mac_ready && (a_frame_rdy || b_frame_rdy)) begin
                        state      <= S_GRANT;
                        busy       <= 1'b1;
                        grant      <= winner;
                        last_grant <= winner;
                        a_len_pop  <= ~winner;
                        b_len_pop  <= winner;
                        len_q      <= winner ? b_frame_len : a_frame_len;
                    end
                end

                S_GRANT: begin
                    if (len_q == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end else begin
                        byte_cnt <= len_q;
                        a_read   <= ~grant;
                        b_read   <= grant;
                        state    <= len_bad ? S_DRAIN : S_SEND;
                    end
                end

                S_SEND, S_DRAIN: begin
                    // byte_cnt holds the number of reads still owed,
                    // including the one issued this cycle.
                    if (byte_cnt <= LEN_W'(1)) begin
                        a_read <= 1'b0;
                        b_read <= 1'b0;
                        if (state == S_SEND) begin
                            state   <= S_IFG;
                            ifg_cnt <= IFG_W'(IFG);
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end
                    end else begin
                        byte_cnt <= byte_cnt - LEN_W'(1);
                    end
                end

                S_IFG: begin
                    if (ifg_cnt <= IFG_W'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ifg_cnt <= ifg_cnt - IFG_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bridge_tx_scheduler
//
// Directed bench for bridge_tx_scheduler. Two small FIFO models supply
// queued frame lengths and byte streams. Port A data is a running byte count.
// Port B data is a running byte count XOR 0xA5. Cycle indices in the checks
// count from the cycle in which the scheduler first sees the new frame in IDLE.
// -----------------------------------------------------------------------------
module tb_bridge_tx_scheduler;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_frame_rdy = 1'b0;
    logic [LEN_W-1:0] a_frame_len = '0;
    logic             a_len_pop;
    logic             a_read;
    logic [7:0]       a_data = 8'h00;
    logic             b_frame_rdy = 1'b0;
    logic [LEN_W-1:0] b_frame_len = '0;
    logic             b_len_pop;
    logic             b_read;
    logic [7:0]       b_data = 8'h00;
    logic             tx_mac_ready;
    logic [7:0]       tx_mac_data;
    logic             tx_mac_valid;
    logic             grant;
    logic             busy;
    logic [7:0]       drop_cnt;
    logic [2:0]       state_dbg;

    bridge_tx_scheduler #(
        .LEN_W(LEN_W), .IFG(12), .MIN_LEN(60), .MAX_LEN(1514)
    ) dut (
        .clk(clk), .rst(rst),
        .a_frame_rdy(a_frame_rdy), .a_frame_len(a_frame_len),
        .a_len_pop(a_len_pop), .a_read(a_read), .a_data(a_data),
        .b_frame_rdy(b_frame_rdy), .b_frame_len(b_frame_len),
        .b_len_pop(b_len_pop), .b_read(b_read), .b_data(b_data),
        .tx_mac_ready(tx_mac_ready), .tx_mac_data(tx_mac_data),
        .tx_mac_valid(tx_mac_valid), .grant(grant), .busy(busy),
        .drop_cnt(drop_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO models ----------------
    logic [LEN_W-1:0] a_tab [0:1023];
    logic [LEN_W-1:0] b_tab [0:1023];
    int a_push = 0, b_push = 0;     // written by the stimulus thread
    int a_pop  = 0, b_pop  = 0;     // written by the model
    int a_ptr  = 0, b_ptr  = 0;
    logic a_rd_p, b_rd_p, a_pop_p, b_pop_p;

    always begin
        @(negedge clk);
        a_rd_p  = a_read;
        b_rd_p  = b_read;
        a_pop_p = a_len_pop;
        b_pop_p = b_len_pop;
        @(posedge clk);
        #1;
        if (a_rd_p) begin
            a_data = 8'(a_ptr);
            a_ptr++;
        end
        if (b_rd_p) begin
            b_data = 8'(b_ptr) ^ 8'hA5;
            b_ptr++;
        end
        if (a_pop_p) a_pop++;
        if (b_pop_p) b_pop++;
        a_frame_rdy = (a_pop != a_push);
        a_frame_len = a_frame_rdy ? a_tab[a_pop] : '0;
        b_frame_rdy = (b_pop != b_push);
        b_frame_len = b_frame_rdy ? b_tab[b_pop] : '0;
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int pop_port[$];
    int pop_cyc[$];
    int runs[$];
    int gaps[$];
    int vdata[$];
    int a_rd_n, b_rd_n, v_n, first_valid, last_valid, run_len, cyc_i;
    int bad_rd = 0;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_a(input int len);
        a_tab[a_push] = LEN_W'(len);
        a_push++;
    endtask

    task automatic push_b(input int len);
        b_tab[b_push] = LEN_W'(len);
        b_push++;
    endtask

    task automatic clear_stats();
        pop_port.delete();
        pop_cyc.delete();
        runs.delete();
        gaps.delete();
        vdata.delete();
        a_rd_n = 0; b_rd_n = 0; v_n = 0;
        first_valid = -1; last_valid = -1; run_len = 0; cyc_i = 0;
    endtask

    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (a_len_pop) begin
                pop_port.push_back(0);
                pop_cyc.push_back(cyc_i);
                chk("grant_on_a_pop", 32'(grant), 32'd0);
            end
            if (b_len_pop) begin
                pop_port.push_back(1);
                pop_cyc.push_back(cyc_i);
                chk("grant_on_b_pop", 32'(grant), 32'd1);
            end
            if (a_read) a_rd_n++;
            if (b_read) b_rd_n++;
            if ((a_read && grant) || (b_read && !grant) || (a_read && b_read)) bad_rd++;
            if (tx_mac_valid) begin
                if (first_valid < 0) first_valid = cyc_i;
                if (run_len == 0 && last_valid >= 0) gaps.push_back(cyc_i - last_valid - 1);
                run_len++;
                v_n++;
                vdata.push_back(int'(tx_mac_data));
                last_valid = cyc_i;
            end else if (run_len != 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            cyc_i++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_read"},    32'(a_read),       32'd0);
        chk({tag, "_b_read"},    32'(b_read),       32'd0);
        chk({tag, "_a_len_pop"}, 32'(a_len_pop),    32'd0);
        chk({tag, "_b_len_pop"}, 32'(b_len_pop),    32'd0);
        chk({tag, "_valid"},     32'(tx_mac_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),         32'd0);
        chk({tag, "_grant"},     32'(grant),        32'd1);
        chk({tag, "_data"},      32'(tx_mac_data),  32'd0);
        chk({tag, "_drop_cnt"},  32'(drop_cnt),     32'd0);
        chk({tag, "_state"},     32'(state_dbg),    32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        tx_mac_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        tx_mac_ready = 1'b1;
        @(negedge clk);

        // A single 64-byte frame on port A with ramp data
        clear_stats();
        push_a(64);
        observe(82);
        chk("s1_pop_count", 32'(pop_cyc.size()), 32'd1);
        chk("s1_pop_cycle", 32'(qat(pop_cyc, 0)), 32'd1);
        chk("s1_pop_port",  32'(qat(pop_port, 0)), 32'd0);
        chk("s1_first_valid", 32'(first_valid), 32'd4);
        chk("s1_run_count", 32'(runs.size()), 32'd1);
        chk("s1_run_len", 32'(qat(runs, 0)), 32'd64);
        chk("s1_a_reads", 32'(a_rd_n), 32'd64);
        chk("s1_b_reads", 32'(b_rd_n), 32'd0);
        bad = 0;
        for (int j = 0; j < v_n; j++) if (vdata[j] != (j & 255)) bad++;
        chk("s1_ramp_data", 32'(bad), 32'd0);
        chk("s1_last_byte", 32'(qat(vdata, 63)), 32'h3F);
        chk("s1_idle_busy", 32'(busy), 32'd0);

        // MAC not ready: frame waits; then ready drops mid-frame
        tx_mac_ready = 1'b0;
        clear_stats();
        push_a(60);
        observe(20);
        chk("s2_no_pop", 32'(pop_cyc.size()), 32'd0);
        chk("s2_no_read", 32'(a_rd_n), 32'd0);
        chk("s2_idle", 32'(busy), 32'd0);
        tx_mac_ready = 1'b1;
        observe(10);
        chk("s2_busy_mid", 32'(busy), 32'd1);
        tx_mac_ready = 1'b0;
        observe(90);
        chk("s2_pop_count", 32'(pop_cyc.size()), 32'd1);
        chk("s2_run_count", 32'(runs.size()), 32'd1);
        chk("s2_run_len", 32'(qat(runs, 0)), 32'd60);
        chk("s2_a_reads", 32'(a_rd_n), 32'd60);
        tx_mac_ready = 1'b1;

        // Short frame is drained, next frame follows without a gap state
        clear_stats();
        push_a(20);
        push_a(60);
        observe(100);
        chk("s3_pop0_cycle", 32'(qat(pop_cyc, 0)), 32'd1);
        chk("s3_pop1_cycle", 32'(qat(pop_cyc, 1)), 32'd23);
        chk("s3_a_reads", 32'(a_rd_n), 32'd80);
        chk("s3_valid_count", 32'(v_n), 32'd60);
        chk("s3_first_valid", 32'(first_valid), 32'd26);
        chk("s3_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("s3_idle", 32'(busy), 32'd0);

        // Lengths 0, 1515 and 59 are dropped
        clear_stats();
        push_a(0);
        push_a(1515);
        push_a(59);
        observe(1590);
        chk("s4_pop1_cycle", 32'(qat(pop_cyc, 1)), 32'd3);
        chk("s4_pop2_cycle", 32'(qat(pop_cyc, 2)), 32'd1520);
        chk("s4_a_reads", 32'(a_rd_n), 32'd1574);
        chk("s4_no_valid", 32'(v_n), 32'd0);
        chk("s4_drop_cnt", 32'(drop_cnt), 32'd4);
        chk("s4_idle", 32'(busy), 32'd0);

        // MAX_LEN is forwarded
        clear_stats();
        push_a(1514);
        observe(1535);
        chk("s5_run_len", 32'(qat(runs, 0)), 32'd1514);
        chk("s5_drop_cnt", 32'(drop_cnt), 32'd4);

        // drop_cnt saturates
        clear_stats();
        for (int j = 0; j < 256; j++) push_a(0);
        observe(520);
        chk("s6_pop_count", 32'(pop_cyc.size()), 32'd256);
        chk("s6_drop_sat", 32'(drop_cnt), 32'd255);
        chk("s6_no_read", 32'(a_rd_n), 32'd0);

        // Reset at byte 30 of a 100-byte frame
        clear_stats();
        push_a(100);
        observe(34);
        chk("s7_bytes_before_rst", 32'(v_n), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;

        // Both ports continuously ready: alternate starting with A
        clear_stats();
        push_a(60);
        push_a(60);
        push_b(60);
        push_b(60);
        observe(310);
        chk("s8_pop_count", 32'(pop_port.size()), 32'd4);
        chk("s8_port0", 32'(qat(pop_port, 0)), 32'd0);
        chk("s8_port1", 32'(qat(pop_port, 1)), 32'd1);
        chk("s8_port2", 32'(qat(pop_port, 2)), 32'd0);
        chk("s8_port3", 32'(qat(pop_port, 3)), 32'd1);
        chk("s8_pop3_cycle", 32'(qat(pop_cyc, 3)), 32'd223);
        chk("s8_run_count", 32'(runs.size()), 32'd4);
        bad = 0;
        for (int j = 0; j < runs.size(); j++) if (runs[j] != 60) bad++;
        chk("s8_run_lens", 32'(bad), 32'd0);
        chk("s8_gap_count", 32'(gaps.size()), 32'd3);
        bad = 0;
        for (int j = 0; j < gaps.size(); j++) if (gaps[j] != 14) bad++;
        chk("s8_gaps", 32'(bad), 32'd0);
        chk("s8_b_first_byte", 32'(qat(vdata, 60)), 32'hA5);
        chk("s8_idle", 32'(busy), 32'd0);

        chk("read_port_rule", 32'(bad_rd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
